tdm_demux4: RTL and testbench

- Receive end of a 4-slot time-division link.
- A 4-to-1 mux with a rotating select serialises four channels onto one line. This block recovers them.
- It samples the line under a slot counter, locks to a frame sync, and assembles four slots into a shadow bank. It then updates the four channel outputs together and pulses a valid strobe.
- It sits between the serial link and the downstream channel logic.

---
 rtl/tdm_demux4_pkg.sv | 25 ++
 rtl/tdm_demux4.sv | 183 ++++++++++++++++++
 tb/tb_tdm_demux4.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/tdm_demux4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux4_pkg
// Description : Shared constants for the 4-slot TDM link. The transmit-side
//               serialiser and the receive-side demux both import this so
//               the two ends agree on frame-state encoding and slot order.
// Contents    : HUNT/LOCK state codes, SLOT0..SLOT3 slot indices, NSLOTS.
// Revision    : 1.0 - initial release
// ============================================================================
package tdm_demux4_pkg;

    // Receiver framing state (1-bit encoding).
    localparam logic [0:0] HUNT = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    // Slot order on the wire; SLOT0 is the slot tagged by the frame marker.
    localparam logic [1:0] SLOT0 = 2'd0;
    localparam logic [1:0] SLOT1 = 2'd1;
    localparam logic [1:0] SLOT2 = 2'd2;
    localparam logic [1:0] SLOT3 = 2'd3;

    localparam int NSLOTS = 4;

endpackage : tdm_demux4_pkg
`default_nettype wire

// File: rtl/tdm_demux4.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux4
// Description : Receive end of a 4-slot time-division link. Samples the
//               serial line under a slot counter, locks to the frame marker,
//               collects a frame in a shadow bank and updates all four
//               channel outputs together at frame completion.
// Ports       : clk         - system clock, rising edge
//               rst         - asynchronous active-high reset
//               d           - serial slot data (WIDTH)
//               en          - sample enable; d/sync ignored while low
//               sync        - frame marker, high with slot-0 data
//               f0..f3      - registered channel outputs (WIDTH)
//               sel         - slot index the next accepted sample fills
//               locked      - high while in LOCK
//               frame_valid - one-cycle pulse after f0..f3 update
//               err         - one-cycle pulse on a sync violation
//               frame_cnt   - completed-frame counter, wraps (CNTW)
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux4
    import tdm_demux4_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             sync,
    output logic [WIDTH-1:0] f0,
    output logic [WIDTH-1:0] f1,
    output logic [WIDTH-1:0] f2,
    output logic [WIDTH-1:0] f3,
    output logic [1:0]       sel,
    output logic             locked,
    output logic             frame_valid,
    output logic             err,
    output logic [CNTW-1:0]  frame_cnt
);

    // Only slots 0..2 need holding: slot 3 goes straight from d to f3 on the
    // completing edge, so the bank is one entry short of a full frame.
    localparam int c_BANK = NSLOTS - 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]       r_state;
    logic [1:0]       r_sel;
    logic [WIDTH-1:0] r_shadow [c_BANK];
    logic [WIDTH-1:0] r_f0, r_f1, r_f2, r_f3;
    logic [CNTW-1:0]  r_cnt;
    logic             r_valid;
    logic             r_err;

    logic [0:0]       w_state_nxt;
    logic [1:0]       w_sel_nxt;
    logic [WIDTH-1:0] w_shadow_nxt [c_BANK];
    logic [WIDTH-1:0] w_f0_nxt, w_f1_nxt, w_f2_nxt, w_f3_nxt;
    logic [CNTW-1:0]  w_cnt_nxt;
    logic             w_valid_nxt;
    logic             w_err_nxt;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= HUNT;
            r_sel    <= SLOT0;
            r_shadow <= '{default: '0};
            r_f0     <= '0;
            r_f1     <= '0;
            r_f2     <= '0;
            r_f3     <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_shadow <= w_shadow_nxt;
            r_f0     <= w_f0_nxt;
            r_f1     <= w_f1_nxt;
            r_f2     <= w_f2_nxt;
            r_f3     <= w_f3_nxt;
            r_cnt    <= w_cnt_nxt;
            r_valid  <= w_valid_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_shadow_nxt = r_shadow;
        w_f0_nxt     = r_f0;
        w_f1_nxt     = r_f1;
        w_f2_nxt     = r_f2;
        w_f3_nxt     = r_f3;
        w_cnt_nxt    = r_cnt;
        w_valid_nxt  = 1'b0;
        w_err_nxt    = 1'b0;

        if (en) begin
            case (r_state)
                HUNT: begin
                    // Unmarked samples are dropped until a frame start shows up.
                    if (sync) begin
                        w_shadow_nxt[SLOT0] = d;
                        w_sel_nxt           = SLOT1;
                        w_state_nxt         = LOCK;
                    end
                end

                LOCK: begin
                    if (sync) begin
                        // A marker mid-frame means the previous frame was
                        // short: discard it but keep lock, since this sample
                        // is itself a valid frame start.
                        if (r_sel != SLOT0) begin
                            w_err_nxt = 1'b1;
                        end
                        w_shadow_nxt[SLOT0] = d;
                        w_sel_nxt           = SLOT1;
                    end else begin
                        case (r_sel)
                            SLOT0: begin
                                // Expected a marker here; framing is lost.
                                w_err_nxt   = 1'b1;
                                w_state_nxt = HUNT;
                            end
                            SLOT1: begin
                                w_shadow_nxt[SLOT1] = d;
                                w_sel_nxt           = SLOT2;
                            end
                            SLOT2: begin
                                w_shadow_nxt[SLOT2] = d;
                                w_sel_nxt           = SLOT3;
                            end
                            default: begin
                                // Frame complete: all four channels change in
                                // this one edge so downstream never sees a mix.
                                w_f0_nxt    = r_shadow[SLOT0];
                                w_f1_nxt    = r_shadow[SLOT1];
                                w_f2_nxt    = r_shadow[SLOT2];
                                w_f3_nxt    = d;
                                w_valid_nxt = 1'b1;
                                w_cnt_nxt   = r_cnt + 1'b1;
                                w_sel_nxt   = SLOT0;
                            end
                        endcase
                    end
                end

                default: begin
                    w_state_nxt = HUNT;
                    w_sel_nxt   = SLOT0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign f0          = r_f0;
    assign f1          = r_f1;
    assign f2          = r_f2;
    assign f3          = r_f3;
    assign sel         = r_sel;
    assign locked      = (r_state == LOCK);
    assign frame_valid = r_valid;
    assign err         = r_err;
    assign frame_cnt   = r_cnt;

endmodule : tdm_demux4
`default_nettype wire

// File: tb/tb_tdm_demux4.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_demux4
// Description : Directed self-checking bench for tdm_demux4. A default
//               instance (WIDTH=1, CNTW=8) and a narrow-counter instance
//               (CNTW=2) share all inputs; the narrow one covers wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux4;

    logic       clk;
    logic       rst;
    logic [0:0] d;
    logic       en;
    logic       sync;

    logic [0:0] f0, f1, f2, f3;
    logic [1:0] sel;
    logic       locked, frame_valid, err;
    logic [7:0] frame_cnt;

    logic [0:0] g0, g1, g2, g3;
    logic [1:0] sel2;
    logic       locked2, frame_valid2, err2;
    logic [1:0] frame_cnt2;

    int n_tests;
    int n_fail;

    tdm_demux4 #(.WIDTH(1), .CNTW(8)) dut (
        .clk(clk), .rst(rst), .d(d), .en(en), .sync(sync),
        .f0(f0), .f1(f1), .f2(f2), .f3(f3),
        .sel(sel), .locked(locked), .frame_valid(frame_valid),
        .err(err), .frame_cnt(frame_cnt)
    );

    tdm_demux4 #(.WIDTH(1), .CNTW(2)) dut2 (
        .clk(clk), .rst(rst), .d(d), .en(en), .sync(sync),
        .f0(g0), .f1(g1), .f2(g2), .f3(g3),
        .sel(sel2), .locked(locked2), .frame_valid(frame_valid2),
        .err(err2), .frame_cnt(frame_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Channels packed as {f0,f1,f2,f3}.
    task automatic chk_f(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, f0, f1, f2, f3}, {28'd0, exp});
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic step(input logic e, input logic dv, input logic s);
        en   = e;
        d    = dv;
        sync = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [3:0] pat [5];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        en = 1'b0; d = 1'b0; sync = 1'b0;

        // ---------------- reset state ----------------
        do_reset();
        chk_f("rst_f", 4'b0000);
        chk("rst_sel", sel, 0);
        chk("rst_locked", locked, 0);
        chk("rst_valid", frame_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_cnt", frame_cnt, 0);

        // ---------------- basic frame 0,1,0,1 ----------------
        step(1, 0, 1);
        chk("basic_locked", locked, 1);
        chk("basic_sel1", sel, 1);
        step(1, 1, 0);
        chk("basic_sel2", sel, 2);
        step(1, 0, 0);
        chk("basic_novalid", frame_valid, 0);
        step(1, 1, 0);
        chk_f("basic_f", 4'b0101);
        chk("basic_valid", frame_valid, 1);
        chk("basic_cnt", frame_cnt, 1);
        chk("basic_sel0", sel, 0);
        step(0, 0, 0);
        chk("basic_valid_clr", frame_valid, 0);
        chk_f("basic_f_hold", 4'b0101);

        // ---------------- hunt discard ----------------
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0);
            chk("hunt_err", err, 0);
            chk("hunt_locked", locked, 0);
            chk("hunt_sel", sel, 0);
        end
        step(1, 1, 1);
        step(1, 0, 0);
        step(1, 1, 0);
        step(1, 0, 0);
        chk_f("hunt_f", 4'b1010);
        chk("hunt_cnt", frame_cnt, 1);

        // ---------------- missing sync ----------------
        step(1, 0, 1);
        step(1, 1, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        chk_f("miss_f0", 4'b0101);
        chk("miss_cnt0", frame_cnt, 2);
        step(1, 1, 0);
        chk("miss_err", err, 1);
        chk("miss_locked", locked, 0);
        chk("miss_sel", sel, 0);
        chk_f("miss_f", 4'b0101);
        step(0, 0, 0);
        chk("miss_err_clr", err, 0);

        // ---------------- early sync ----------------
        step(1, 1, 1);
        chk("early_locked", locked, 1);
        step(1, 1, 0);
        chk("early_sel2", sel, 2);
        step(1, 0, 1);
        chk("early_err", err, 1);
        chk("early_locked2", locked, 1);
        chk("early_sel1", sel, 1);
        chk("early_novalid", frame_valid, 0);
        chk_f("early_f_hold", 4'b0101);
        chk("early_cnt_hold", frame_cnt, 2);
        step(1, 0, 0);
        chk("early_err_once", err, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        chk_f("early_f", 4'b0001);
        chk("early_valid", frame_valid, 1);
        chk("early_cnt", frame_cnt, 3);

        // ---------------- gaps between samples ----------------
        step(1, 1, 1);
        repeat (3) step(0, 0, 0);
        chk("gap_locked", locked, 1);
        chk("gap_sel", sel, 1);
        step(1, 1, 0);
        repeat (3) step(0, 1, 1);
        chk("gap_sel2", sel, 2);
        chk("gap_err", err, 0);
        step(1, 0, 0);
        repeat (3) step(0, 0, 0);
        chk("gap_novalid", frame_valid, 0);
        step(1, 0, 0);
        chk_f("gap_f", 4'b1100);
        chk("gap_valid", frame_valid, 1);
        chk("gap_cnt", frame_cnt, 4);
        step(0, 0, 0);
        chk("gap_valid_once", frame_valid, 0);

        // ---------------- asynchronous reset mid-frame ----------------
        step(1, 0, 1);
        step(1, 1, 0);
        chk("arst_pre_sel", sel, 2);
        en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_f("arst_f", 4'b0000);
        chk("arst_sel", sel, 0);
        chk("arst_locked", locked, 0);
        chk("arst_cnt", frame_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, 1, 0);
        chk("arst_hunt_locked", locked, 0);
        chk("arst_hunt_err", err, 0);

        // ---------------- back-to-back frames, CNTW=2 wrap ----------------
        do_reset();
        pat[0] = 4'b1000;
        pat[1] = 4'b0100;
        pat[2] = 4'b0010;
        pat[3] = 4'b0001;
        pat[4] = 4'b1011;
        for (int k = 0; k < 5; k++) begin
            for (int s = 0; s < 4; s++) begin
                step(1, pat[k][3-s], (s == 0));
                chk("wrap_valid", frame_valid2, (s == 3) ? 1 : 0);
            end
            chk("wrap_cnt2", frame_cnt2, (k + 1) % 4);
            chk("wrap_cnt8", frame_cnt, k + 1);
            chk("wrap_f2", {28'd0, g0, g1, g2, g3}, {28'd0, pat[k]});
        end
        step(0, 0, 0);
        chk("wrap_valid_end", frame_valid2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_tdm_demux4
`default_nettype wire
